// File: rtl/synchronizer.sv
// rtl/synchronizer.sv - multi-flop CDC synchronizer for a DATA_WIDTH-bit bus
// Optional feature macro: SYNCHRONIZER_COHERENT_EN (output-hold register that only
// accepts words seen identical in the last two ranks).
module synchronizer #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    STAGES     = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out
);

  // A chain shorter than two ranks gives no metastability settling time.
  if (STAGES < 2) begin : g_bad_stages
    $error("synchronizer: STAGES must be >= 2");
  end

  // Ranks kept adjacent with nothing between them so placement can pack them tightly.
  (* ASYNC_REG = "TRUE" *) logic [DATA_WIDTH-1:0] sync [STAGES];

  // Shift chain: rank 0 captures the asynchronous bus, each later rank re-times the previous one.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) sync[i] <= RESET_VAL;
    end else begin
      sync[0] <= d_in;
      for (int i = 1; i < STAGES; i++) sync[i] <= sync[i-1];
    end
  end

`ifdef SYNCHRONIZER_COHERENT_EN
  logic [DATA_WIDTH-1:0] out_q;

  // Only pass a word once the last two ranks agree, so a skewed multi-bit change never reaches d_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= RESET_VAL;
    end else if (sync[STAGES-1] == sync[STAGES-2]) begin
      out_q <= sync[STAGES-1];
    end
  end

  assign d_out = out_q;
`else
  assign d_out = sync[STAGES-1];
`endif

endmodule

// File: tb/tb_synchronizer.sv
// tb/tb_synchronizer.sv - directed table-driven bench for synchronizer (default and 8-bit/3-stage builds)
module tb_synchronizer;

  logic        clk;
  logic        rst32;
  logic [31:0] d32;
  logic [31:0] q32;
  logic        rst8;
  logic [7:0]  d8;
  logic [7:0]  q8;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        rst;
    logic [31:0] d;
    logic [31:0] exp;
    logic [31:0] exp_coh;
  } vec_t;

  vec_t tab32 [19];
  vec_t tab8  [17];

  synchronizer dut32 (
    .clk   (clk),
    .rst   (rst32),
    .d_in  (d32),
    .d_out (q32)
  );

  synchronizer #(
    .DATA_WIDTH (8),
    .STAGES     (3),
    .RESET_VAL  (8'hA5)
  ) dut8 (
    .clk   (clk),
    .rst   (rst8),
    .d_in  (d8),
    .d_out (q8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic [31:0] d, logic [31:0] e, logic [31:0] ec);
    vec_t v;
    v.rst = r;
    v.d = d;
    v.exp = e;
    v.exp_coh = ec;
    return v;
  endfunction

  function automatic logic [31:0] pick(vec_t v);
`ifdef SYNCHRONIZER_COHERENT_EN
    return v.exp_coh;
`else
    return v.exp;
`endif
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    // 32-bit, STAGES=2: latency, streaming, mid-stream reset, rst-wins-same-edge
    tab32[0]  = mk(0, 32'hDEADBEEF, 32'h0,        32'h0);
    tab32[1]  = mk(0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0);
    tab32[2]  = mk(0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    tab32[3]  = mk(0, 32'h1,        32'hDEADBEEF, 32'hDEADBEEF);
    tab32[4]  = mk(0, 32'h2,        32'h1,        32'hDEADBEEF);
    tab32[5]  = mk(0, 32'h3,        32'h2,        32'hDEADBEEF);
    tab32[6]  = mk(0, 32'h4,        32'h3,        32'hDEADBEEF);
    tab32[7]  = mk(0, 32'h5,        32'h4,        32'hDEADBEEF);
    tab32[8]  = mk(0, 32'h5,        32'h5,        32'hDEADBEEF);
    tab32[9]  = mk(0, 32'h5,        32'h5,        32'h5);
    tab32[10] = mk(0, 32'h11,       32'h5,        32'h5);
    tab32[11] = mk(0, 32'h22,       32'h11,       32'h5);
    tab32[12] = mk(1, 32'h33,       32'h0,        32'h0);
    tab32[13] = mk(0, 32'h44,       32'h0,        32'h0);
    tab32[14] = mk(0, 32'h44,       32'h44,       32'h0);
    tab32[15] = mk(0, 32'h44,       32'h44,       32'h44);
    tab32[16] = mk(0, 32'h55,       32'h44,       32'h44);
    tab32[17] = mk(0, 32'h55,       32'h55,       32'h44);
    tab32[18] = mk(0, 32'h55,       32'h55,       32'h55);

    // 8-bit, STAGES=3, RESET_VAL=A5: release latency, alternating bus, then settle on 3C
    tab8[0]  = mk(1, 32'h00, 32'hA5, 32'hA5);
    tab8[1]  = mk(0, 32'h3C, 32'hA5, 32'hA5);
    tab8[2]  = mk(0, 32'h3C, 32'hA5, 32'hA5);
    tab8[3]  = mk(0, 32'h3C, 32'h3C, 32'hA5);
    tab8[4]  = mk(0, 32'h3C, 32'h3C, 32'h3C);
    tab8[5]  = mk(0, 32'h5A, 32'h3C, 32'h3C);
    tab8[6]  = mk(0, 32'h5A, 32'h3C, 32'h3C);
    tab8[7]  = mk(0, 32'h5A, 32'h5A, 32'h3C);
    tab8[8]  = mk(0, 32'h00, 32'h5A, 32'h5A);
    tab8[9]  = mk(0, 32'hFF, 32'h5A, 32'h5A);
    tab8[10] = mk(0, 32'h00, 32'h00, 32'h5A);
    tab8[11] = mk(0, 32'hFF, 32'hFF, 32'h5A);
    tab8[12] = mk(0, 32'h00, 32'h00, 32'h5A);
    tab8[13] = mk(0, 32'h3C, 32'hFF, 32'h5A);
    tab8[14] = mk(0, 32'h3C, 32'h00, 32'h5A);
    tab8[15] = mk(0, 32'h3C, 32'h3C, 32'h5A);
    tab8[16] = mk(0, 32'h3C, 32'h3C, 32'h3C);

    rst32 = 1'b1;
    rst8  = 1'b1;
    d32   = '0;
    d8    = '0;

    // Reset hold with random input on both instances
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      d32 = $urandom;
      d8  = 8'($urandom);
      @(posedge clk);
      #1;
      chk("reset_hold32", i, q32, 32'h0);
      chk("reset_hold8", i, {24'h0, q8}, 32'hA5);
    end

    // 32-bit instance sequence; 8-bit instance stays in reset
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      rst32 = tab32[i].rst;
      d32   = tab32[i].d;
      @(posedge clk);
      #1;
      chk("seq32", i, q32, pick(tab32[i]));
      chk("hold8", i, {24'h0, q8}, 32'hA5);
    end

    // 8-bit instance sequence
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      rst8 = tab8[i].rst;
      d8   = tab8[i].d[7:0];
      @(posedge clk);
      #1;
      chk("seq8", i, {24'h0, q8}, pick(tab8[i]));
    end

    // Output must not move between edges even if the input does
    @(negedge clk);
    d8 = 8'h81;
    #2;
    chk("no_comb_path8", 0, {24'h0, q8}, 32'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
